// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, keyboard command
// bytes and default timing for a 50 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game core (master) and the PS/2 host
// transmitter (slave).
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (output tx_data, output tx_valid,
                    input  tx_ready, input tx_done, input tx_error);
    modport slave  (input  tx_data, input tx_valid,
                    output tx_ready, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge
// detector on each synchronized line. Shared with the keyboard receiver.
module ps2_line_sync (
    input  logic clock,
    input  logic resetn,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_o,
    output logic dat_o,
    output logic clk_fe_o,
    output logic dat_fe_o
);
    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0] meta_q, cur_q, prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; reset to the idle-high
    // bus level so no false edge appears when reset releases.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 2'b11;
            cur_q  <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            meta_q <= {ps2_dat_i, ps2_clk_i};
            cur_q  <= meta_q;
            prev_q <= cur_q;
        end
    end

    assign clk_o    = cur_q[0];
    assign dat_o    = cur_q[1];
    assign clk_fe_o = prev_q[0] & ~cur_q[0];
    assign dat_fe_o = prev_q[1] & ~cur_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send
// and shifts one command byte out on device clock falling edges.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clock,
    input  logic         resetn,
    ps2_host_tx_if.slave tx,
    output logic         rx_inhibit,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             dat_bit_q, dat_bit_d;

    logic clk_s, dat_s, clk_fe, dat_fe;
    logic busy, inh_last, timeout;

    ps2_line_sync u_sync (
        .clock    (clock),
        .resetn   (resetn),
        .ps2_clk_i(ps2_clk_in),
        .ps2_dat_i(ps2_dat_in),
        .clk_o    (clk_s),
        .dat_o    (dat_s),
        .clk_fe_o (clk_fe),
        .dat_fe_o (dat_fe)
    );

    assign busy     = state_q inside {REQ, DATA, PARITY, ACK, WAIT_IDLE};
    assign inh_last = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
    assign timeout  = busy && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            dat_bit_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            dat_bit_q <= dat_bit_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned and no latch is inferred.
        state_d   = state_q;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        dat_bit_d = dat_bit_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (tx.tx_valid) begin
                    data_d   = tx.tx_data;
                    parity_d = odd_parity(tx.tx_data);
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_cnt_d = inh_last ? '0 : inh_cnt_q + INH_W'(1);
                if (inh_last) state_d = REQ;
            end
            REQ: begin
                if (clk_fe) begin
                    dat_bit_d = data_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fe) begin
                    if (bit_cnt_q == 4'd8) begin
                        dat_bit_d = parity_q;
                        state_d   = PARITY;
                    end else begin
                        dat_bit_d = data_q[bit_cnt_q[2:0]];
                    end
                end
            end
            PARITY:    if (clk_fe) state_d = ACK;
            ACK:       if (clk_fe) state_d = dat_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (clk_s && dat_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (busy) to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fe && (state_q inside {REQ, DATA, PARITY, ACK}))
            bit_cnt_d = bit_cnt_q + 4'd1;
        // Timeout overrides a coincident final edge.
        if (timeout) state_d = IDLE;
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_dat_oe  = 1'b0;
        tx.tx_done  = 1'b0;
        tx.tx_error = 1'b0;
        case (state_q)
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = inh_last;
            end
            REQ:          ps2_dat_oe  = 1'b1;
            DATA, PARITY: ps2_dat_oe  = ~dat_bit_q;
            ACK:          tx.tx_error = clk_fe & dat_s;
            WAIT_IDLE:    tx.tx_done  = clk_s & dat_s;
            default:      ;
        endcase
        if (timeout) begin
            ps2_clk_oe  = 1'b0;
            ps2_dat_oe  = 1'b0;
            tx.tx_done  = 1'b0;
            tx.tx_error = 1'b1;
        end
    end

    assign tx.tx_ready = (state_q == IDLE);
    assign rx_inhibit  = (state_q != IDLE);

endmodule
